key_debounce: RTL and testbench

- Front-end conditioning stage for the key-count path.
- Synchronises a raw, bouncing, active-low mechanical key input to Clk and filters out bounce with a 4-state FSM plus hold-off counter.
- Key_out is a clean, active-high, single-transition "pressed" level. It drives the Cin input of the period/edge counter stage directly downstream, so every rising edge of Key_out is exactly one confirmed key press.
- Also emits one-cycle press/release strobes and a running press count.

---
 rtl/key_debounce.sv | 130 +++++++++++++
 tb/tb_key_debounce.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Debounces a raw active-low key into a clean active-high pressed level.
// Also produces one-cycle press/release strobes and a wrapping press count.
//
// state     | meaning
// ----------|---------------------------------------------------
// IDLE      | released and stable; waiting for a falling edge
// PRESS_FLT | press seen; counting stable-low cycles
// DOWN      | pressed and stable; waiting for a rising edge
// REL_FLT   | release seen; counting stable-high cycles
module key_debounce #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned PCNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Key_in,
  output logic              Key_out,
  output logic              Key_press,
  output logic              Key_release,
  output logic [PCNT_W-1:0] Press_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_FLT = 2'd1,
    DOWN      = 2'd2,
    REL_FLT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic                key_out_q, key_out_d;
  logic                key_press_q, key_press_d;
  logic                key_release_q, key_release_d;
  logic [PCNT_W-1:0]   press_cnt_q, press_cnt_d;
  logic                fall, rise;

  // Only the settled synchroniser taps feed the FSM.
  assign fall = s2_q & ~s1_q;
  assign rise = ~s2_q & s1_q;

  always_comb begin
    s0_d          = Key_in;
    s1_d          = s0_q;
    s2_d          = s1_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    key_out_d     = key_out_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    press_cnt_d   = press_cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = PRESS_FLT;
      end
      PRESS_FLT: begin
        // An opposite edge wins over a simultaneous terminal count.
        if (rise) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d     = DOWN;
          cnt_d       = '0;
          key_out_d   = 1'b1;
          key_press_d = 1'b1;
          press_cnt_d = press_cnt_q + PCNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        cnt_d = '0;
        if (rise) state_d = REL_FLT;
      end
      REL_FLT: begin
        if (fall) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d       = IDLE;
          cnt_d         = '0;
          key_out_d     = 1'b0;
          key_release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Synchroniser resets to released so a key held through reset is seen as a fall.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s0_q          <= 1'b1;
      s1_q          <= 1'b1;
      s2_q          <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      key_out_q     <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      press_cnt_q   <= '0;
    end else begin
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_out_q     <= key_out_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      press_cnt_q   <= press_cnt_d;
    end
  end

  assign Key_out     = key_out_q;
  assign Key_press   = key_press_q;
  assign Key_release = key_release_q;
  assign Press_cnt   = press_cnt_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with a short hold-off and narrow press count.
module tb_key_debounce;

  localparam int DB  = 8;
  localparam int PW  = 4;
  localparam int LAT = DB + 3;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Key_in = 1'b1;
  logic          Key_out, Key_press, Key_release;
  logic [PW-1:0] Press_cnt;

  typedef struct {
    bit            is_press;
    int            cyc;
    logic [PW-1:0] cnt;
  } ev_t;

  ev_t           sb_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [PW-1:0] exp_cnt = '0;
  logic          prev_out = 1'b0;
  logic          prev_valid = 1'b0;

  key_debounce #(.DB_CYCLES(DB), .CNT_W(4), .PCNT_W(PW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Key_in(Key_in), .Key_out(Key_out),
    .Key_press(Key_press), .Key_release(Key_release), .Press_cnt(Press_cnt)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard consumer: every strobe must match the oldest expected event.
  always @(negedge Clk) begin
    ev_t ev;
    if (Rst_n && prev_valid) begin
      if (Key_press || Key_release) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe cyc=%0d press=%b release=%b, required no strobe", cyc, Key_press, Key_release);
        end else begin
          ev = sb_q.pop_front();
          if (Key_press !== ev.is_press || Key_release !== !ev.is_press || cyc != ev.cyc ||
              Key_out !== ev.is_press || Press_cnt !== ev.cnt) begin
            failures++;
            $display("FAIL strobe_event got press=%b rel=%b cyc=%0d out=%b cnt=%0d, required press=%b cyc=%0d cnt=%0d",
                     Key_press, Key_release, cyc, Key_out, Press_cnt, ev.is_press, ev.cyc, ev.cnt);
          end
        end
      end else if (Key_out !== prev_out) begin
        checks++;
        failures++;
        $display("FAIL out_change_without_strobe cyc=%0d got=%b, required=%b", cyc, Key_out, prev_out);
      end
    end
    prev_out   = Key_out;
    prev_valid = Rst_n;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drain(input int budget, output int pending);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    pending = sb_q.size();
    sb_q.delete();
  endtask

  task automatic push_ev(input bit is_press, input int at);
    ev_t ev;
    if (is_press) exp_cnt = exp_cnt + 1'b1;
    ev.is_press = is_press;
    ev.cyc      = at;
    ev.cnt      = exp_cnt;
    sb_q.push_back(ev);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Key_in = 1'b1;
    tick(3);
    checks++;
    if ({Key_out, Key_press, Key_release} !== 3'b000 || Press_cnt !== '0) begin
      failures++;
      $display("FAIL reset_values got out=%b press=%b rel=%b cnt=%0d, required 0 0 0 0", Key_out, Key_press, Key_release, Press_cnt);
    end
    Rst_n = 1'b1;
    tick(50);
    checks++;
    if (Key_out !== 1'b0 || Press_cnt !== '0) begin
      failures++;
      $display("FAIL idle_hold got out=%b cnt=%0d, required out=0 cnt=0", Key_out, Press_cnt);
    end
  endtask

  task automatic test_clean_press();
    int pend;
    Key_in = 1'b0;
    push_ev(1'b1, cyc + LAT);
    drain(LAT + 5, pend);
    checks++;
    if (pend !== 0 || Key_out !== 1'b1 || Key_press !== 1'b0 || Press_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL clean_press got pend=%0d out=%b press=%b cnt=%0d, required pend=0 out=1 press=0 cnt=%0d",
               pend, Key_out, Key_press, Press_cnt, exp_cnt);
    end
  endtask

  task automatic test_release();
    int pend;
    Key_in = 1'b1;
    push_ev(1'b0, cyc + LAT);
    drain(LAT + 5, pend);
    checks++;
    if (pend !== 0 || Key_out !== 1'b0 || Key_release !== 1'b0 || Press_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL release got pend=%0d out=%b rel=%b cnt=%0d, required pend=0 out=0 rel=0 cnt=%0d",
               pend, Key_out, Key_release, Press_cnt, exp_cnt);
    end
  endtask

  task automatic test_bouncy_press();
    int pend;
    for (int i = 0; i < 4; i++) begin
      Key_in = i[0];
      tick(3);
    end
    Key_in = 1'b0;
    push_ev(1'b1, cyc + LAT);
    drain(LAT + 5, pend);
    checks++;
    if (pend !== 0 || Key_out !== 1'b1 || Press_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL bouncy_press got pend=%0d out=%b cnt=%0d, required pend=0 out=1 cnt=%0d", pend, Key_out, Press_cnt, exp_cnt);
    end
  endtask

  task automatic test_glitch(input logic level);
    logic base;
    base   = ~level;
    Key_in = level;
    tick(5);
    Key_in = base;
    tick(25);
    checks++;
    if (Key_out !== ~base || Press_cnt !== exp_cnt || sb_q.size() != 0) begin
      failures++;
      $display("FAIL glitch_%0b got out=%b cnt=%0d, required out=%b cnt=%0d", level, Key_out, Press_cnt, ~base, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    int pend;
    int bad = 0;
    logic [PW-1:0] start_cnt;
    start_cnt = exp_cnt;
    for (int i = 0; i < (1 << PW) + 3; i++) begin
      Key_in = 1'b0;
      push_ev(1'b1, cyc + LAT);
      drain(LAT + 5, pend);
      bad += pend;
      tick(2);
      Key_in = 1'b1;
      push_ev(1'b0, cyc + LAT);
      drain(LAT + 5, pend);
      bad += pend;
      tick(2);
    end
    checks++;
    if (bad != 0 || Press_cnt !== start_cnt + PW'(3)) begin
      failures++;
      $display("FAIL press_cnt_wrap got cnt=%0d timeouts=%0d, required cnt=%0d timeouts=0", Press_cnt, bad, start_cnt + PW'(3));
    end
  endtask

  task automatic test_reset_mid();
    int pend;
    Key_in = 1'b0;
    tick(LAT - 3);
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({Key_out, Key_press, Key_release} !== 3'b000 || Press_cnt !== '0) begin
      failures++;
      $display("FAIL reset_mid_values got out=%b press=%b rel=%b cnt=%0d, required 0 0 0 0", Key_out, Key_press, Key_release, Press_cnt);
    end
    exp_cnt = '0;
    tick(4);
    Rst_n = 1'b1;
    push_ev(1'b1, cyc + LAT);
    drain(LAT + 5, pend);
    checks++;
    if (pend !== 0 || Key_out !== 1'b1 || Press_cnt !== PW'(1)) begin
      failures++;
      $display("FAIL reset_mid_press got pend=%0d out=%b cnt=%0d, required pend=0 out=1 cnt=1", pend, Key_out, Press_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bouncy_press();
    test_glitch(1'b1);
    test_release();
    test_glitch(1'b0);
    test_wrap();
    test_reset_mid();
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
